// File: rtl/lcd_framebuffer_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_framebuffer_writer
// Brief    : Packs 2-bit PPU pixels four-per-byte and queues them as
//            framebuffer writes through a small FIFO.
//            Define LCD_FB_DOUBLE_BUFFER_EN to flip fb_addr[13] each frame.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_framebuffer_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic        ppu_hblank,
    input  logic        ppu_vblank,
    output logic [13:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic        frame_done,
    output logic        overflow
);

    localparam int                 c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH  = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]         c_PIXELS = 8'd160;
    localparam logic [7:0]         c_LINES  = 8'd144;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_VBLANK = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    state_t               r_state;
    logic [7:0]           r_x;
    logic [7:0]           r_y;
    logic [7:0]           r_pack;
    logic                 r_frame_done;
    logic                 r_overflow;

    logic [12:0]          r_mem_addr [FIFO_DEPTH];
    logic [7:0]           r_mem_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic                 w_bank;
    logic                 w_accept;
    logic                 w_push_req;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_drain_done;
    logic [12:0]          w_y13;
    logic [12:0]          w_addr;
    logic [7:0]           w_data;

    assign fb_valid   = (r_count != '0);
    assign fb_addr    = {w_bank, r_mem_addr[r_rd_ptr]};
    assign fb_data    = r_mem_data[r_rd_ptr];
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

    assign w_accept     = (r_state == ST_ACTIVE) && !ppu_vblank && !ppu_hblank &&
                          pixel_valid && (r_x < c_PIXELS) && (r_y < c_LINES);
    assign w_push_req   = w_accept && (r_x[1:0] == 2'b11);
    assign w_full       = (r_count == c_DEPTH);
    assign w_pop        = fb_valid && fb_ready;
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_drop       = w_push_req && w_full && !w_pop;
    assign w_drain_done = (r_state == ST_DRAIN) && !fb_valid;

    // Line base is y*40 = y*32 + y*8.
    assign w_y13  = {5'd0, r_y};
    assign w_addr = (w_y13 << 5) + (w_y13 << 3) + {7'd0, r_x[7:2]};
    assign w_data = {pixel_in, r_pack[5:0]};

`ifdef LCD_FB_DOUBLE_BUFFER_EN
    logic r_bank;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_bank <= 1'b0;
        else if (w_drain_done)
            r_bank <= ~r_bank;
    end
    assign w_bank = r_bank;
`else
    assign w_bank = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_addr[r_wr_ptr] <= w_addr;
                r_mem_data[r_wr_ptr] <= w_data;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SYNC;
            r_x          <= '0;
            r_y          <= '0;
            r_pack       <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_drop)
                r_overflow <= 1'b1;
            case (r_state)
                ST_SYNC: begin
                    if (ppu_vblank)
                        r_state <= ST_VBLANK;
                end
                ST_VBLANK: begin
                    if (!ppu_vblank) begin
                        r_state    <= ST_ACTIVE;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_pack     <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (ppu_vblank) begin
                        r_state <= ST_DRAIN;
                    end else if (ppu_hblank) begin
                        r_state <= ST_HBLANK;
                        r_x     <= '0;
                        r_pack  <= '0;
                        if (r_y != c_LINES)
                            r_y <= r_y + 8'd1;
                    end else if (w_accept) begin
                        r_x <= r_x + 8'd1;
                        case (r_x[1:0])
                            2'd0:    r_pack[1:0] <= pixel_in;
                            2'd1:    r_pack[3:2] <= pixel_in;
                            2'd2:    r_pack[5:4] <= pixel_in;
                            default: r_pack      <= '0;
                        endcase
                    end
                end
                ST_HBLANK: begin
                    if (ppu_vblank)
                        r_state <= ST_DRAIN;
                    else if (!ppu_hblank)
                        r_state <= ST_ACTIVE;
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state      <= ST_VBLANK;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= ST_SYNC;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_framebuffer_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_framebuffer_writer
// Brief    : Directed self-checking bench for lcd_framebuffer_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_framebuffer_writer;

`ifdef LCD_FB_DOUBLE_BUFFER_EN
    localparam int c_BANK1 = 'h2000;
`else
    localparam int c_BANK1 = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        ppu_hblank = 1'b0;
    logic        ppu_vblank = 1'b0;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_valid;
    logic        fb_ready = 1'b1;
    logic        frame_done;
    logic        overflow;

    int          n_vec = 0;
    int          n_miss = 0;
    bit          toggle = 1'b0;

    logic [13:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    int          fd_n = 0;
    longint      cyc = 0;
    longint      last_wr_cyc = 0;
    longint      fd_cyc = 0;
    int          unstable = 0;
    bit          prev_stall = 1'b0;
    logic [13:0] prev_addr;
    logic [7:0]  prev_data;

    lcd_framebuffer_writer #(.FIFO_DEPTH(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .ppu_hblank  (ppu_hblank),
        .ppu_vblank  (ppu_vblank),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_valid    (fb_valid),
        .fb_ready    (fb_ready),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change 2ns after the rising edge, so values seen on the falling
    // edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (fb_valid && fb_ready) begin
                wr_addr.push_back(fb_addr);
                wr_data.push_back(fb_data);
                last_wr_cyc = cyc;
            end
            if (frame_done) begin
                fd_n++;
                fd_cyc = cyc;
            end
            if (prev_stall && (fb_addr != prev_addr || fb_data != prev_data))
                unstable++;
            prev_stall = fb_valid && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (toggle)
            fb_ready = ~fb_ready;
    endtask

    function automatic logic [1:0] shade(input int mode, input int line, input int i);
        if (mode == 1 || (mode == 2 && line[0]))
            return 2'd3;
        return 2'(i % 4);
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic drive_line(input int n, input int mode, input int line, input bit lat);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            pixel_in    = shade(mode, line, i);
            if (lat && i == 3) chk("lat_pre", fb_valid, 0);
            tick();
            if (lat && i == 3) chk("lat_1", fb_valid, 1);
        end
        pixel_valid = 1'b0;
        ppu_hblank  = 1'b1;
        repeat (6) tick();
        ppu_hblank  = 1'b0;
        tick();
    endtask

    // mode 0: every byte 0xE4, mode 1: every byte 0xFF, mode 2: by line parity
    task automatic check_run(input string tag, input int n, input int base, input int mode);
        int bad;
        int idx;
        logic [7:0] exp_d;
        bad = 0;
        chk({tag, "_count"}, wr_addr.size(), n);
        for (int i = 0; i < wr_addr.size() && i < n; i++) begin
            idx   = base + i;
            exp_d = (mode == 1 || (mode == 2 && (((idx & 'h1FFF) / 40) % 2 == 1))) ? 8'hFF : 8'hE4;
            if (wr_addr[i] !== 14'(idx) || wr_data[i] !== exp_d)
                bad++;
        end
        chk({tag, "_bad_entries"}, bad, 0);
    endtask

    task automatic wait_fd(input int target, input string tag);
        int k;
        k = 0;
        while (fd_n < target && k < 400) begin
            tick();
            k++;
        end
        chk(tag, fd_n, target);
    endtask

    initial begin
        logic [13:0] last_a;

        repeat (2) tick();
        chk("rst_valid", fb_valid, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_data, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // Frame 0: enter via a vblank pulse
        drive_line(8, 0, 0, 0);
        chk("sync_ignore", wr_addr.size(), 0);
        ppu_vblank = 1'b1;
        repeat (3) tick();
        ppu_vblank = 1'b0;
        repeat (2) tick();
        chk("fd_sync", fd_n, 0);

        clear_log();
        drive_line(160, 0, 0, 1);
        check_run("line0", 40, 0, 0);

        clear_log();
        drive_line(160, 1, 1, 0);
        check_run("line1", 40, 40, 1);

        clear_log();
        fb_ready = 1'b0;
        drive_line(160, 0, 2, 0);
        chk("stall_ovf", overflow, 1);
        chk("stall_valid", fb_valid, 1);
        chk("stall_addr", fb_addr, 80);
        chk("stall_data", fb_data, 8'hE4);
        chk("stall_nowr", wr_addr.size(), 0);
        chk("stall_stable", unstable, 0);
        fb_ready = 1'b1;
        repeat (8) tick();
        check_run("stall_rel", 4, 80, 0);
        chk("ovf_sticky", overflow, 1);

        clear_log();
        drive_line(6, 0, 3, 0);
        repeat (2) tick();
        check_run("partial", 1, 120, 0);

        clear_log();
        drive_line(8, 1, 4, 0);
        repeat (2) tick();
        check_run("x_restart", 2, 160, 1);

        ppu_vblank = 1'b1;
        wait_fd(1, "fd0");
        chk("ovf_vblank", overflow, 1);
        ppu_vblank = 1'b0;
        repeat (2) tick();
        chk("ovf_clr", overflow, 0);

        // Frame 1: full frame with fb_ready toggling every cycle
        clear_log();
        fd_n   = 0;
        toggle = 1'b1;
        for (int ln = 0; ln < 144; ln++)
            drive_line(160, 2, ln, 0);
        drive_line(8, 1, 144, 0);
        ppu_vblank = 1'b1;
        wait_fd(1, "fd1");
        toggle   = 1'b0;
        fb_ready = 1'b1;
        repeat (4) tick();
        check_run("frame", 5760, c_BANK1, 2);
        last_a = (wr_addr.size() > 0) ? wr_addr[wr_addr.size() - 1] : '0;
        chk("frame_last", last_a, c_BANK1 + 5759);
        chk("fd_once", fd_n, 1);
        chk("fd_after_wr", (fd_cyc > last_wr_cyc) ? 1 : 0, 1);
        chk("frame_ovf", overflow, 0);
        chk("frame_stable", unstable, 0);

        // Frame 2: reset with two bytes pending
        ppu_vblank = 1'b0;
        repeat (2) tick();
        fb_ready = 1'b0;
        drive_line(8, 0, 0, 0);
        chk("pend_valid", fb_valid, 1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", fb_valid, 0);
        chk("midrst_addr", fb_addr, 0);
        clear_log();
        fb_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        drive_line(160, 0, 0, 0);
        chk("postrst_nowr", wr_addr.size(), 0);
        ppu_vblank = 1'b1;
        repeat (2) tick();
        ppu_vblank = 1'b0;
        repeat (2) tick();
        drive_line(8, 1, 0, 0);
        repeat (2) tick();
        check_run("postrst", 2, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_framebuffer_writer.md
LCD_FRAMEBUFFER_WRITER -- requirements
Module: lcd_framebuffer_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of packed-byte write-FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk  input  1  clock (4 MHz PPU clock).
REQ-003 SHALL have port reset  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port pixel_in  input  2  pixel shade from the PPU.
REQ-005 SHALL have port pixel_valid  input  1  pixel_in is valid this cycle.
REQ-006 SHALL have port ppu_hblank  input  1  PPU is in HBlank.
REQ-007 SHALL have port ppu_vblank  input  1  PPU is in VBlank.
REQ-008 SHALL have port fb_addr  output  14  framebuffer byte address; bit 13 is the bank.
REQ-009 SHALL have port fb_data  output  8  packed byte of 4 pixels.
REQ-010 SHALL have port fb_valid  output  1  write request.
REQ-011 SHALL have port fb_ready  input  1  framebuffer accepts the write.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when a frame is fully written.
REQ-013 SHALL have port overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-014 SHALL run an FSM with states SYNC, VBLANK, ACTIVE, HBLANK and DRAIN.
REQ-015 SHALL transition SYNC->VBLANK when ppu_vblank=1, with no frame_done; all pixels SHALL be ignored in SYNC.
REQ-016 SHALL transition VBLANK->ACTIVE when ppu_vblank=0, clearing x=0, y=0, the pack register and overflow.
REQ-017 SHALL accept a pixel in ACTIVE only when pixel_valid=1, ppu_hblank=0, x<160 and y<144; on acceptance x increments.
REQ-018 SHALL pack pixels LSB-first: pixel with x%4=k SHALL go to bits [2k+1:2k].
REQ-019 SHALL push {addr = y*40 + x/4, data} into the FIFO on the cycle the 4th pixel (x%4=3) is accepted.
REQ-020 SHALL transition ACTIVE->HBLANK on ppu_hblank=1; y increments (saturating at 144), x=0, and any partial byte is discarded.
REQ-021 SHALL transition HBLANK->ACTIVE on ppu_hblank=0 with ppu_vblank=0.
REQ-022 SHALL transition ACTIVE or HBLANK->DRAIN on ppu_vblank=1; vblank SHALL take priority over hblank.
REQ-023 SHALL transition DRAIN->VBLANK when the FIFO is empty and no transfer is pending, asserting frame_done for exactly that cycle.
REQ-024 SHALL, if ppu_vblank falls while in DRAIN, finish the drain first, then pass through VBLANK and enter ACTIVE on the following cycle.
REQ-025 SHALL drive fb_valid=1 exactly when the FIFO is non-empty; fb_addr and fb_data SHALL show the head entry and hold stable while fb_valid=1 and fb_ready=0.
REQ-026 SHALL pop the FIFO on fb_valid && fb_ready.
REQ-027 SHALL accept a simultaneous push and pop when the FIFO is full.
REQ-028 SHALL, on a push to a full FIFO with no pop, drop the byte and set overflow=1 until the next VBLANK->ACTIVE transition.
REQ-029 SHALL give a latency of 1 cycle from the 4th pixel's acceptance edge to fb_valid when the FIFO is empty.
REQ-030 SHALL drive fb_addr[13]=bank per the Configuration section.

Reset
REQ-031 SHALL, while reset=1, immediately force: state=SYNC, x=0, y=0, pack register=0, FIFO empty, fb_valid=0, fb_addr=0, fb_data=0, frame_done=0, overflow=0, bank=0.
REQ-032 SHALL discard any in-flight FIFO contents on reset asserted mid-frame, with no write emitted after release.

Configuration
REQ-033 SHALL, with macro LCD_FB_DOUBLE_BUFFER_EN defined, toggle bank on every frame_done pulse, so frame N writes bank N%2.
REQ-034 SHALL, without LCD_FB_DOUBLE_BUFFER_EN, hold bank=0 and tie fb_addr[13]=0.

Verification
REQ-035 SHALL cover: reset, vblank pulse, then one line of 160 pixels with shades 0,1,2,3 repeating and fb_ready=1 -> 40 writes, addr 0..39, each data=0xE4.
REQ-036 SHALL cover: line 1 of 160 pixels all shade 3 -> 40 writes, addr 40..79, data=0xFF.
REQ-037 SHALL cover: fb_ready=0 for a full line, FIFO_DEPTH=4 -> 4 bytes held, overflow=1, fb_addr stable; after fb_ready=1, exactly 4 writes, then overflow clears at the next frame start.
REQ-038 SHALL cover: 6 pixels then hblank -> 1 write (addr y*40), partial byte dropped, next line starts at x=0.
REQ-039 SHALL cover: full 144-line frame then vblank with fb_ready toggling 50% -> 5760 writes, last addr 5759, one frame_done after the last write; with LCD_FB_DOUBLE_BUFFER_EN defined, the second frame uses addresses 0x2000-0x367F.
REQ-040 SHALL cover: reset asserted mid-line with 2 FIFO entries pending -> fb_valid=0 during reset, no writes until after the next vblank->active transition.
